// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state, width defaults and result type for the iterative divider
package div_pkg;

   localparam int DIV_DW    = 32;
   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;

   typedef struct packed {
      logic [DIV_DW-1:0] quotient;
      logic [DIV_DW-1:0] remainder;
   } div_res_t;

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response handshake bundle between EX stage and divider
interface div_iter_unit_if #(parameter int DW = 32);

   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [DW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [DW-1:0] remainder;
   logic          busy;

   modport master (
      output in_valid, in_signed, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, busy
   );

   modport slave (
      input  in_valid, in_signed, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, busy
   );

endinterface

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division iteration
module div_iter_step #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] rem_i,
   input  logic          bit_i,
   input  logic [DW-1:0] dsr_i,
   output logic [DW-1:0] rem_o,
   output logic          q_o
);

   logic [DW:0] trial;

   // The partial remainder stays below the divisor, so bit DW of the trial is its sign.
   always_comb begin
      trial = {rem_i, bit_i} - {1'b0, dsr_i};
      q_o   = ~trial[DW];
      rem_o = q_o ? trial[DW-1:0] : {rem_i[DW-2:0], bit_i};
   end

endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - radix-2 restoring DIV/DIVU unit for the HI/LO path
// Optional macro DIV_ZERO_FASTPATH_EN: divide by zero completes one cycle after accept.
module div_iter_unit
   import div_pkg::*;
#(
   parameter int DW    = DIV_DW,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           flush,
   div_iter_unit_if.slave bus
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    dvd_q, dvd_d;
   logic [DW-1:0]    dsr_q, dsr_d;
   logic [DW-1:0]    rem_q, rem_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   div_res_t         res_q, res_d;

   logic [DW-1:0]    step_rem;
   logic             step_q;
   logic             accept;

   div_iter_step #(.DW(DW)) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[DW-1]),
      .dsr_i (dsr_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign bus.in_ready  = (state_q == IDLE) && !flush;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.quotient  = res_q.quotient;
   assign bus.remainder = res_q.remainder;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               dvd_d   = (bus.in_signed && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
               dsr_d   = (bus.in_signed && bus.divisor[DW-1])  ? -bus.divisor  : bus.divisor;
               q_neg_d = bus.in_signed && (bus.dividend[DW-1] ^ bus.divisor[DW-1]);
               r_neg_d = bus.in_signed && bus.dividend[DW-1];
               rem_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
`ifdef DIV_ZERO_FASTPATH_EN
               if (bus.divisor == '0) begin
                  state_d         = DONE;
                  res_d.quotient  = '1;
                  res_d.remainder = bus.dividend;
               end
`endif
            end
         end
         CALC: begin
            // Quotient bits enter at the LSB as dividend bits leave the MSB.
            rem_d = step_rem;
            dvd_d = {dvd_q[DW-2:0], step_q};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DW-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            res_d.quotient  = q_neg_q ? -dvd_q : dvd_q;
            res_d.remainder = r_neg_q ? -rem_q : rem_q;
            state_d         = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - self-checking bench for div_iter_unit
module tb_div_iter_unit;

   logic clk;
   logic resetn;
   logic flush;
   int   checks;
   int   failures;

   div_iter_unit_if #(.DW(32)) bus ();

   div_iter_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
      if (b == 32'd0) return 1;
`endif
      return 34;
   endfunction

   // Reference built from integer arithmetic; returns {quotient, remainder}.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [31:0] q, r;
      if (b == 32'd0) begin
`ifdef DIV_ZERO_FASTPATH_EN
         q = 32'hFFFF_FFFF;
         r = a;
`else
         // all-ones quotient on |a|, remainder |a|, then sign fix from a's sign
         q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
`endif
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
      int lat;
      bus.in_signed = s;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.in_valid  = 1'b1;
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.in_signed = 1'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_latency(b)));
      check({tag, " quotient"}, bus.quotient, eq);
      check({tag, " remainder"}, bus.remainder, er);
      if (bus.out_ready) begin
         @(posedge clk); #1;
         check({tag, " out_valid after pop"}, 32'(bus.out_valid), 32'd0);
         check({tag, " busy after pop"}, 32'(bus.busy), 32'd0);
      end
   endtask

   initial begin
      vec_t        vecs[$];
      logic [63:0] m;
      logic        seen;
      logic [31:0] a, b;
      logic        s;

      checks    = 0;
      failures  = 0;
      resetn    = 1'b0;
      flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;

      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset quotient", bus.quotient, 32'd0);
      check("reset remainder", bus.remainder, 32'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
      check("idle in_ready", 32'(bus.in_ready), 32'd1);

      vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,        32'd2});
      vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE});
      vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0});
      vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1});
      vecs.push_back('{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 32'h0000_1234});
      vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{1'b0, 32'd5,          32'd9,          32'd0,         32'd5});
`ifdef DIV_ZERO_FASTPATH_EN
      vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FF9C});
`else
      vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd0,          32'd1,         32'hFFFF_FF9C});
`endif
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      end

      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(1, 20));
            1: b = 32'd0;
            2: b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         m = model(s, a, b);
         run_op($sformatf("rand%0d", i), s, a, b, m[63:32], m[31:0]);
      end

      // Backpressure: result held while the consumer stalls.
      bus.out_ready = 1'b0;
      run_op("bp", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp out_valid held", 32'(bus.out_valid), 32'd1);
         check("bp quotient held", bus.quotient, 32'd100);
         check("bp busy", 32'(bus.busy), 32'd1);
         check("bp in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp in_ready after pop", 32'(bus.in_ready), 32'd1);
      check("bp out_valid after pop", 32'(bus.out_valid), 32'd0);

      // Flush at T+10 together with a new request.
      bus.in_signed = 1'b0;
      bus.dividend  = 32'h1000;
      bus.divisor   = 32'd3;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.dividend  = 32'd50;
      bus.divisor   = 32'd5;
      check("flush in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("flush busy", 32'(bus.busy), 32'd0);
      check("flush out_valid", 32'(bus.out_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen |= bus.out_valid;
      end
      check("flush no result", 32'(seen), 32'd0);
      run_op("post_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

      // Asynchronous reset in the middle of CALC.
      bus.in_signed = 1'b0;
      bus.dividend  = 32'd77;
      bus.divisor   = 32'd4;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midcalc busy", 32'(bus.busy), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("async reset busy", 32'(bus.busy), 32'd0);
      check("async reset out_valid", 32'(bus.out_valid), 32'd0);
      check("async reset quotient", bus.quotient, 32'd0);
      check("async reset remainder", bus.remainder, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("after reset no result", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
